stream_demux2: RTL and testbench
================================

# stream_demux2

Registered 1-to-2 stream demultiplexer: the sequential counterpart of the team's 2:1 mux. It accepts one valid/ready input stream whose beats carry a lane-select bit and steers each beat into one of two buffered output streams, A or B. Each lane has its own small FIFO, so one stalled lane does not stall the other until a beat for the stalled lane reaches the input. It sits between a shared producer and two independent consumers.

## Interface
- WIDTH, 8, data width of every beat
- DEPTH, 2, entries per lane FIFO; power of two, at least 2
- CNT_W, 16, width of the per-lane accepted-beat counters
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  WIDTH  input beat payload
- in_sel  in  1  lane select: 0 routes to lane A, 1 routes to lane B
- in_valid  in  1  input beat present
- in_ready  out  1  input beat accepted this cycle when high together with in_valid
- a_data / b_data  out  WIDTH  lane head payload
- a_valid / b_valid  out  1  lane head present
- a_ready / b_ready  in  1  consumer takes the lane head
- a_cnt / b_cnt  out  CNT_W  beats accepted into the lane since reset

## Operation
- Transfer rule on every interface: a beat moves on the rising edge when valid and ready are both high.
- in_ready = (in_sel ? !b_full : !a_full). This is combinational from in_sel and registered full flags only; it never depends on a_ready or b_ready.
- An accepted beat is written to the tail of the selected lane FIFO. The other lane is untouched.
- A lane is full when it holds DEPTH entries. When a lane is full, in_ready stays low for beats targeting that lane, even if the same lane pops in the same cycle. There is no write-through when full.
- The producer must hold in_data and in_sel stable while in_valid is high and in_ready is low. Behaviour on violation is unspecified, but no beat may be duplicated into both lanes.
- Lane valid = FIFO not empty. Lane data = FIFO head, driven from the storage array and registered pointers.
- Simultaneous push and pop on the same non-full, non-empty lane: occupancy is unchanged and both take effect.
- Pointers are log2(DEPTH) bits and wrap naturally. The occupancy counter is log2(DEPTH)+1 bits.
- a_cnt / b_cnt increment by 1 on each accepted beat into their lane, modulo 2^CNT_W (0xFFFF+1 = 0x0000).
- Beat order within a lane is preserved. Relative order across lanes is not guaranteed at the outputs.

## Timing
- Reset (asynchronous, immediate on rst rising, held while high):
  - all FIFOs empty;
  - a_valid = b_valid = 0, a_cnt = b_cnt = 0;
  - a_data and b_data are don't-care but driven as 0 from the reset storage pointer head;
  - in_ready = 1 while rst is high is permitted, but no beat is accepted.
- Reset mid-operation: all buffered beats are discarded without being presented. Lane valids fall in the same cycle, not at the next edge.
- Latency: a beat accepted at edge N drives lane valid high from just after edge N, so it is consumable at edge N+1. Minimum input-to-output latency is 1 cycle.
- Throughput: one beat per cycle per input with DEPTH ≥ 2 and a consumer that is always ready.
- First cycle after rst deasserts: in_ready follows in_sel normally (both lanes empty, so 1).

## Structure
- Shared package stream_demux_pkg:
  - lane constants LANE_A = 1'b0, LANE_B = 1'b1;
  - the default WIDTH, DEPTH and CNT_W values.
- Sub-module stream_fifo (WIDTH, DEPTH):
  - ports clk, rst, push, push_data, pop, head_data, empty, full;
  - instantiated twice.
- The top level holds the routing logic, the in_ready mux and the two counters.

## Test plan
- Reset: drive in_valid = 1, in_sel = 0, in_data = 0x11 with rst high for 3 cycles -> a_valid = b_valid = 0, a_cnt = 0 throughout; after release, 0x11 appears on lane A one cycle later and a_cnt = 1.
- Routing: send 0xA0 (sel 0), 0xB0 (sel 1), 0xA1 (sel 0) back to back with both readies high -> lane A outputs 0xA0 then 0xA1, lane B outputs 0xB0; a_cnt = 2, b_cnt = 1.
- Lane A full, lane B free: a_ready = 0, push 0x01 and 0x02 to A, then 0x03 to A with 0x10 waiting behind it:
  - in_ready is low while 0x03 is offered, and the 0x10 beat (sel 1) cannot bypass it;
  - raise a_ready for one cycle -> next cycle in_ready goes high and 0x03 is accepted;
  - 0x10 then reaches lane B.
- Full plus pop, same cycle: lane A holds 2 entries, a_ready = 1, new beat offered for A -> in_ready = 0 that cycle; the beat is accepted the following cycle.
- Counter wrap: with CNT_W = 4, push 17 beats into lane B -> b_cnt reads 0x1 and all 17 payloads exit in order.
- Async reset mid-stream: with 2 beats in A and 1 in B, pulse rst between edges -> a_valid and b_valid drop before the next edge; no pre-reset payload ever appears afterwards.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer and its lane FIFOs.
// Lane encodings match the in_sel bit; defaults size the top-level parameters.
package stream_demux_pkg;

  localparam logic LANE_A = 1'b0;
  localparam logic LANE_B = 1'b1;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_CNT_W = 16;

endpackage : stream_demux_pkg

// File: rtl/stream_fifo.sv
// Small synchronous FIFO used as one output lane of stream_demux2.
// Head data comes straight from storage at the registered read pointer.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [OCC_W-1:0] occ_r;
  logic             do_push_s;
  logic             do_pop_s;

  // A push into a full FIFO is dropped here as well, so no write-through can occur.
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  assign empty     = (occ_r == {OCC_W{1'b0}});
  assign full      = (occ_r == OCC_W'(DEPTH));
  assign head_data = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy; storage clears so the reset head reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

endmodule : stream_fifo

// File: rtl/stream_demux2.sv
// Registered 1-to-2 stream demultiplexer: routes each input beat by in_sel into
// one of two buffered lanes and counts the beats accepted into each lane.
module stream_demux2
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt
);

  logic             a_full_s;
  logic             b_full_s;
  logic             a_empty_s;
  logic             b_empty_s;
  logic             in_ready_s;
  logic             a_push_s;
  logic             b_push_s;
  logic [CNT_W-1:0] a_cnt_r;
  logic [CNT_W-1:0] b_cnt_r;

  // Readiness looks only at the selected lane's registered full flag, never at consumer readies.
  always_comb begin
    in_ready_s = 1'b0;
    case (in_sel)
      LANE_A:  in_ready_s = !a_full_s;
      LANE_B:  in_ready_s = !b_full_s;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Steer an accepted beat to exactly one lane.
  always_comb begin
    a_push_s = 1'b0;
    b_push_s = 1'b0;
    if (in_valid && in_ready_s) begin
      a_push_s = (in_sel == LANE_A);
      b_push_s = (in_sel == LANE_B);
    end else begin
      a_push_s = 1'b0;
      b_push_s = 1'b0;
    end
  end

  // Per-lane accepted-beat counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_cnt_r <= {CNT_W{1'b0}};
      b_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (a_push_s) begin
        a_cnt_r <= a_cnt_r + CNT_W'(1);
      end
      if (b_push_s) begin
        b_cnt_r <= b_cnt_r + CNT_W'(1);
      end
    end
  end

  stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane_a (
    .clk       (clk),
    .rst       (rst),
    .push      (a_push_s),
    .push_data (in_data),
    .pop       (a_ready),
    .head_data (a_data),
    .empty     (a_empty_s),
    .full      (a_full_s)
  );

  stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane_b (
    .clk       (clk),
    .rst       (rst),
    .push      (b_push_s),
    .push_data (in_data),
    .pop       (b_ready),
    .head_data (b_data),
    .empty     (b_empty_s),
    .full      (b_full_s)
  );

  assign in_ready = in_ready_s;
  assign a_valid  = !a_empty_s;
  assign b_valid  = !b_empty_s;
  assign a_cnt    = a_cnt_r;
  assign b_cnt    = b_cnt_r;

endmodule : stream_demux2

// File: tb/tb_stream_demux2.sv
// Self-checking bench for stream_demux2: directed scenarios plus randomized
// traffic compared against a queue-based model of the two lanes.
module tb_stream_demux2;
  import stream_demux_pkg::*;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_data;
  logic          a_valid;
  logic          a_ready;
  logic [W-1:0]  b_data;
  logic          b_valid;
  logic          b_ready;
  logic [CW-1:0] a_cnt;
  logic [CW-1:0] b_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: each lane is a bounded queue; counters count accepted beats modulo 2^CW.
  logic [W-1:0] q_a[$];
  logic [W-1:0] q_b[$];
  int           cnt_a;
  int           cnt_b;
  logic [W-1:0] obs_a[$];
  logic [W-1:0] obs_b[$];
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];

  stream_demux2 #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_cnt    (a_cnt),
    .b_cnt    (b_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic model_ready();
    return in_sel ? (q_b.size() < D) : (q_a.size() < D);
  endfunction

  task automatic model_clear();
    q_a.delete(); q_b.delete();
    obs_a.delete(); obs_b.delete();
    exp_a.delete(); exp_b.delete();
    cnt_a = 0; cnt_b = 0;
  endtask

  task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
    in_valid = v; in_sel = s; in_data = d;
    #1;
  endtask

  // Advance one clock: record DUT pops, apply the same transfer to the model.
  task automatic tick();
    logic acc;
    acc = in_valid && model_ready();
    if (a_ready && a_valid) obs_a.push_back(a_data);
    if (b_ready && b_valid) obs_b.push_back(b_data);
    if (a_ready && q_a.size() > 0) exp_a.push_back(q_a.pop_front());
    if (b_ready && q_b.size() > 0) exp_b.push_back(q_b.pop_front());
    if (acc) begin
      if (in_sel == LANE_A) begin
        q_a.push_back(in_data);
        cnt_a = (cnt_a + 1) % (1 << CW);
      end else begin
        q_b.push_back(in_data);
        cnt_b = (cnt_b + 1) % (1 << CW);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_ready = 1'b0; b_ready = 1'b0;
    drive(1'b1, LANE_A, 8'h11);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (a_valid !== 1'b0 || b_valid !== 1'b0 || a_cnt !== 4'h0 || a_data !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_hold: a_valid=%b b_valid=%b a_cnt=%h a_data=%h, want 0 0 0 00", a_valid, b_valid, a_cnt, a_data);
      end
    end
    rst = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
    end
    tick();
    drive(1'b0, LANE_A, 8'h00);
    n_checks++;
    if (a_valid !== 1'b1 || a_data !== 8'h11 || a_cnt !== 4'h1 || b_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_beat: a_valid=%b a_data=%h a_cnt=%h b_valid=%b, want 1 11 1 0", a_valid, a_data, a_cnt, b_valid);
    end
  endtask

  task automatic test_routing();
    do_reset();
    a_ready = 1'b1; b_ready = 1'b1;
    drive(1'b1, LANE_A, 8'hA0); tick();
    drive(1'b1, LANE_B, 8'hB0); tick();
    drive(1'b1, LANE_A, 8'hA1); tick();
    drive(1'b0, LANE_A, 8'h00);
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (obs_a.size() != 2 || obs_b.size() != 1) begin
      n_fail++; $display("FAIL route_count: a=%0d b=%0d beats, want 2 1", obs_a.size(), obs_b.size());
    end else if (obs_a[0] !== 8'hA0 || obs_a[1] !== 8'hA1 || obs_b[0] !== 8'hB0) begin
      n_fail++; $display("FAIL route_data: a=%h,%h b=%h want a0,a1 b0", obs_a[0], obs_a[1], obs_b[0]);
    end
    n_checks++;
    if (a_cnt !== 4'h2 || b_cnt !== 4'h1) begin
      n_fail++; $display("FAIL route_cnt: a_cnt=%h b_cnt=%h want 2 1", a_cnt, b_cnt);
    end
  endtask

  task automatic test_lane_full();
    do_reset();
    a_ready = 1'b0; b_ready = 1'b1;
    drive(1'b1, LANE_A, 8'h01); tick();
    drive(1'b1, LANE_A, 8'h02); tick();
    drive(1'b1, LANE_A, 8'h03);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (in_ready !== 1'b0 || b_valid !== 1'b0) begin
        n_fail++; $display("FAIL full_block: in_ready=%b b_valid=%b want 0 0", in_ready, b_valid);
      end
      tick();
    end
    a_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_pop_same_cycle: in_ready=%b want 0", in_ready);
    end
    tick();
    a_ready = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_after_pop: in_ready=%b want 1", in_ready);
    end
    tick();
    drive(1'b1, LANE_B, 8'h10); tick();
    drive(1'b0, LANE_A, 8'h00);
    n_checks++;
    if (b_valid !== 1'b1 || b_data !== 8'h10) begin
      n_fail++; $display("FAIL full_b_beat: b_valid=%b b_data=%h want 1 10", b_valid, b_data);
    end
    a_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (obs_a.size() != 3 || obs_b.size() != 1) begin
      n_fail++; $display("FAIL full_order_count: a=%0d b=%0d beats, want 3 1", obs_a.size(), obs_b.size());
    end else if (obs_a[0] !== 8'h01 || obs_a[1] !== 8'h02 || obs_a[2] !== 8'h03) begin
      n_fail++; $display("FAIL full_order: a=%h,%h,%h want 01,02,03", obs_a[0], obs_a[1], obs_a[2]);
    end
    n_checks++;
    if (a_cnt !== 4'h3 || b_cnt !== 4'h1) begin
      n_fail++; $display("FAIL full_cnt: a_cnt=%h b_cnt=%h want 3 1", a_cnt, b_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, LANE_B, 8'(8'h20 + i));
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL wrap_ready: beat %0d in_ready=%b want 1", i, in_ready);
      end
      tick();
    end
    drive(1'b0, LANE_A, 8'h00);
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (b_cnt !== 4'h1 || a_cnt !== 4'h0) begin
      n_fail++; $display("FAIL wrap_cnt: b_cnt=%h a_cnt=%h want 1 0", b_cnt, a_cnt);
    end
    n_checks++;
    if (obs_b.size() != 17) begin
      n_fail++; $display("FAIL wrap_count: %0d beats want 17", obs_b.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        if (obs_b[i] !== 8'(8'h20 + i)) begin
          n_fail++; $display("FAIL wrap_data: beat %0d got %h want %h", i, obs_b[i], 8'(8'h20 + i));
          break;
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    a_ready = 1'b0; b_ready = 1'b0;
    drive(1'b1, LANE_A, 8'hC1); tick();
    drive(1'b1, LANE_A, 8'hC2); tick();
    drive(1'b1, LANE_B, 8'hD1); tick();
    drive(1'b0, LANE_A, 8'h00);
    n_checks++;
    if (a_valid !== 1'b1 || b_valid !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre: a_valid=%b b_valid=%b want 1 1", a_valid, b_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0 || a_cnt !== 4'h0 || b_cnt !== 4'h0) begin
      n_fail++; $display("FAIL areset_drop: a_valid=%b b_valid=%b a_cnt=%h b_cnt=%h want 0 0 0 0", a_valid, b_valid, a_cnt, b_cnt);
    end
    rst = 1'b0;
    model_clear();
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (obs_a.size() != 0 || obs_b.size() != 0) begin
      n_fail++; $display("FAIL areset_stale: a=%0d b=%0d beats after reset, want 0 0", obs_a.size(), obs_b.size());
    end
  endtask

  task automatic test_random();
    logic acc;
    do_reset();
    drive(1'b0, LANE_A, 8'h00);
    for (int c = 0; c < 400; c++) begin
      a_ready = 1'($urandom_range(0, 3) != 0);
      b_ready = 1'($urandom_range(0, 2) != 0);
      #1;
      n_checks++;
      if (in_ready !== model_ready()) begin
        n_fail++; $display("FAIL rand_ready: cycle %0d in_ready=%b want %b", c, in_ready, model_ready());
      end
      n_checks++;
      if (a_valid !== (q_a.size() > 0) || (q_a.size() > 0 && a_data !== q_a[0])) begin
        n_fail++; $display("FAIL rand_lane_a: cycle %0d a_valid=%b a_data=%h want valid=%b", c, a_valid, a_data, q_a.size() > 0);
      end
      n_checks++;
      if (b_valid !== (q_b.size() > 0) || (q_b.size() > 0 && b_data !== q_b[0])) begin
        n_fail++; $display("FAIL rand_lane_b: cycle %0d b_valid=%b b_data=%h want valid=%b", c, b_valid, b_data, q_b.size() > 0);
      end
      n_checks++;
      if (a_cnt !== CW'(cnt_a) || b_cnt !== CW'(cnt_b)) begin
        n_fail++; $display("FAIL rand_cnt: cycle %0d a_cnt=%h b_cnt=%h want %h %h", c, a_cnt, b_cnt, CW'(cnt_a), CW'(cnt_b));
      end
      acc = in_valid && model_ready();
      tick();
      if (acc || !in_valid) begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      end
    end
    drive(1'b0, LANE_A, 8'h00);
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (obs_a != exp_a || obs_b != exp_b) begin
      n_fail++; $display("FAIL rand_stream: a got %0d beats want %0d, b got %0d want %0d (or data differs)", obs_a.size(), exp_a.size(), obs_b.size(), exp_b.size());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = 8'h00;
    a_ready = 1'b0; b_ready = 1'b0;
    model_clear();
    #2;
    test_reset();
    test_routing();
    test_lane_full();
    test_counter_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_stream_demux2
